// File: rtl/operand_sequencer.sv
// ---------------------------------------------------------------------------
// operand_sequencer
//
// Collects two 3-bit operands and a 3-bit opcode from a set of switches, one
// value per rising edge of the (already debounced) enter button. It then
// issues a single-cycle push strobe to the downstream result stack. The
// cancel button aborts a partial entry.
//
// If the stack is full, the opcode entry is refused and err is set. err is
// sticky: only a cancel or a later accepted advance clears it.
//
// Optional feature (compile-time macro OPSEQ_TIMEOUT_EN):
//   When defined, a partial entry that has been idle in S_B or S_OP for
//   TIMEOUT_CYCLES clocks is aborted back to S_A and err is set.
//   When undefined, there is no counter and S_B/S_OP wait indefinitely.
//
// Parameters:
//   TIMEOUT_CYCLES - idle cycles before a partial entry aborts (2..4095)
//
// Ports:
//   clk_300hz   in   sole clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   sw[2:0]     in   operand/opcode switches, sampled on an accepted enter edge
//   enter       in   write button level; only rising edges matter
//   cancel      in   read/cancel button level; only rising edges matter
//   lifo_full   in   full flag from the result stack
//   a_out[2:0]  out  latched operand A
//   b_out[2:0]  out  latched operand B
//   opcode_out  out  latched raw opcode (3 bits)
//   calc_pulse  out  registered single-cycle push strobe
//   stage[1:0]  out  current state: 0=S_A 1=S_B 2=S_OP 3=S_ISSUE
//   err         out  sticky error (stack full on issue, or timeout)
// ---------------------------------------------------------------------------
module operand_sequencer #(
    parameter int TIMEOUT_CYCLES = 3000
) (
    input  logic       clk_300hz,
    input  logic       reset_n,
    input  logic [2:0] sw,
    input  logic       enter,
    input  logic       cancel,
    input  logic       lifo_full,
    output logic [2:0] a_out,
    output logic [2:0] b_out,
    output logic [2:0] opcode_out,
    output logic       calc_pulse,
    output logic [1:0] stage,
    output logic       err
);

    typedef enum logic [1:0] {
        S_A     = 2'd0,
        S_B     = 2'd1,
        S_OP    = 2'd2,
        S_ISSUE = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic enter_q;
    logic cancel_q;
    logic enter_rise;
    logic cancel_rise;

    logic load_a;
    logic load_b;
    logic load_op;
    logic set_err;
    logic clr_err;
    logic timeout_hit;

    assign enter_rise  = enter & ~enter_q;
    assign cancel_rise = cancel & ~cancel_q;
    assign stage       = state;

    // Edge-detect history resets to 1. A button that is held through reset
    // release is then seen as "already high", so it produces no edge.
    // NOTE: sequential state is written with non-blocking (<=) assignments,
    // so every register samples values from before the clock edge.
    always_ff @(posedge clk_300hz or negedge reset_n) begin
        if (!reset_n) begin
            enter_q  <= 1'b1;
            cancel_q <= 1'b1;
        end else begin
            enter_q  <= enter;
            cancel_q <= cancel;
        end
    end

    always_ff @(posedge clk_300hz or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_A;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and latch-enable decode. Cancel has priority over enter,
    // and enter has priority over timeout. S_ISSUE ignores both buttons.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        next_state = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        load_op    = 1'b0;
        set_err    = 1'b0;
        clr_err    = 1'b0;

        unique case (state)
            S_A: begin
                if (cancel_rise) begin
                    clr_err = 1'b1;
                end else if (enter_rise) begin
                    load_a     = 1'b1;
                    clr_err    = 1'b1;
                    next_state = S_B;
                end
            end
            S_B: begin
                if (cancel_rise) begin
                    clr_err    = 1'b1;
                    next_state = S_A;
                end else if (enter_rise) begin
                    load_b     = 1'b1;
                    clr_err    = 1'b1;
                    next_state = S_OP;
                end else if (timeout_hit) begin
                    set_err    = 1'b1;
                    next_state = S_A;
                end
            end
            S_OP: begin
                if (cancel_rise) begin
                    clr_err    = 1'b1;
                    next_state = S_A;
                end else if (enter_rise) begin
                    // The opcode is latched even when the push is refused,
                    // so a retry simply re-latches it.
                    load_op = 1'b1;
                    if (lifo_full) begin
                        set_err = 1'b1;
                    end else begin
                        clr_err    = 1'b1;
                        next_state = S_ISSUE;
                    end
                end else if (timeout_hit) begin
                    set_err    = 1'b1;
                    next_state = S_A;
                end
            end
            S_ISSUE: begin
                next_state = S_A;
            end
            default: begin
                next_state = S_A;
            end
        endcase
    end

    // The data latches are reset because reset must drive all outputs to 0.
    always_ff @(posedge clk_300hz or negedge reset_n) begin
        if (!reset_n) begin
            a_out      <= 3'd0;
            b_out      <= 3'd0;
            opcode_out <= 3'd0;
        end else begin
            if (load_a) begin
                a_out <= sw;
            end
            if (load_b) begin
                b_out <= sw;
            end
            if (load_op) begin
                opcode_out <= sw;
            end
        end
    end

    // calc_pulse is registered from the decoded next state. It is therefore
    // high for exactly the cycle in which state is S_ISSUE, and reset clears
    // it asynchronously.
    always_ff @(posedge clk_300hz or negedge reset_n) begin
        if (!reset_n) begin
            calc_pulse <= 1'b0;
            err        <= 1'b0;
        end else begin
            calc_pulse <= (next_state == S_ISSUE);
            if (set_err) begin
                err <= 1'b1;
            end else if (clr_err) begin
                err <= 1'b0;
            end
        end
    end

`ifdef OPSEQ_TIMEOUT_EN
    localparam logic [11:0] TIMEOUT_LAST = 12'(TIMEOUT_CYCLES - 1);

    logic [11:0] idle_count;

    // Counts idle cycles in S_B or S_OP. Any state change or accepted enter
    // edge restarts the count.
    always_ff @(posedge clk_300hz or negedge reset_n) begin
        if (!reset_n) begin
            idle_count <= 12'd0;
        end else if ((next_state != state) || enter_rise ||
                     !((state == S_B) || (state == S_OP))) begin
            idle_count <= 12'd0;
        end else begin
            idle_count <= idle_count + 12'd1;
        end
    end

    assign timeout_hit = (idle_count == TIMEOUT_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_operand_sequencer.sv
// ---------------------------------------------------------------------------
// tb_operand_sequencer
//
// Directed bench for operand_sequencer. A table of {inputs, expected outputs}
// records covers the entry sequence, the full-stack retry, cancel priority,
// held-enter behaviour and err clearing. Hand-written sequences cover reset
// with enter held, the timeout (both builds) and reset during S_ISSUE.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that
// same point after the next edge.
// ---------------------------------------------------------------------------
module tb_operand_sequencer;

    logic       clk_300hz;
    logic       reset_n;
    logic [2:0] sw;
    logic       enter;
    logic       cancel;
    logic       lifo_full;
    logic [2:0] a_out;
    logic [2:0] b_out;
    logic [2:0] opcode_out;
    logic       calc_pulse;
    logic [1:0] stage;
    logic       err;

    int n_cmp  = 0;
    int n_fail = 0;

    operand_sequencer #(.TIMEOUT_CYCLES(4)) dut (
        .clk_300hz  (clk_300hz),
        .reset_n    (reset_n),
        .sw         (sw),
        .enter      (enter),
        .cancel     (cancel),
        .lifo_full  (lifo_full),
        .a_out      (a_out),
        .b_out      (b_out),
        .opcode_out (opcode_out),
        .calc_pulse (calc_pulse),
        .stage      (stage),
        .err        (err)
    );

    initial clk_300hz = 1'b0;
    always #5 clk_300hz = ~clk_300hz;

    typedef struct {
        logic [2:0] sw;
        logic       en;
        logic       ca;
        logic       lf;
        logic [1:0] st;
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] op;
        logic       calc;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int s, int e, int c, int l, int st, int a,
                                int b, int op, int calc, int er);
        vec_t v;
        v.sw   = 3'(s);
        v.en   = 1'(e);
        v.ca   = 1'(c);
        v.lf   = 1'(l);
        v.st   = 2'(st);
        v.a    = 3'(a);
        v.b    = 3'(b);
        v.op   = 3'(op);
        v.calc = 1'(calc);
        v.err  = 1'(er);
        return v;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk_300hz);
        #1;
    endtask

    task automatic check_all(input string tag, input int st, input int a, input int b,
                             input int op, input int calc, input int er);
        check({tag, " stage"}, int'(stage), st);
        check({tag, " a_out"}, int'(a_out), a);
        check({tag, " b_out"}, int'(b_out), b);
        check({tag, " opcode_out"}, int'(opcode_out), op);
        check({tag, " calc_pulse"}, int'(calc_pulse), calc);
        check({tag, " err"}, int'(err), er);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #3;
        @(negedge clk_300hz);
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        reset_n   = 1'b0;
        sw        = 3'd0;
        enter     = 1'b0;
        cancel    = 1'b0;
        lifo_full = 1'b0;

        //          sw en ca lf   st  a  b op calc err
        // Basic entry 3,5,2: stage 1,2,3,0 with a single push
        vecs.push_back(mk(3, 1, 0, 0,  1, 3, 0, 0, 0, 0));
        vecs.push_back(mk(3, 0, 0, 0,  1, 3, 0, 0, 0, 0));
        vecs.push_back(mk(5, 1, 0, 0,  2, 3, 5, 0, 0, 0));
        vecs.push_back(mk(5, 0, 0, 0,  2, 3, 5, 0, 0, 0));
        vecs.push_back(mk(2, 1, 0, 0,  3, 3, 5, 2, 1, 0));
        vecs.push_back(mk(2, 0, 0, 0,  0, 3, 5, 2, 0, 0));
        vecs.push_back(mk(2, 0, 0, 0,  0, 3, 5, 2, 0, 0));
        // Stack full: refused, retry re-latches opcode, then issue clears err
        vecs.push_back(mk(1, 1, 0, 0,  1, 1, 5, 2, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,  1, 1, 5, 2, 0, 0));
        vecs.push_back(mk(6, 1, 0, 0,  2, 1, 6, 2, 0, 0));
        vecs.push_back(mk(6, 0, 0, 0,  2, 1, 6, 2, 0, 0));
        vecs.push_back(mk(4, 1, 0, 1,  2, 1, 6, 4, 0, 1));
        vecs.push_back(mk(4, 0, 0, 1,  2, 1, 6, 4, 0, 1));
        vecs.push_back(mk(7, 1, 0, 1,  2, 1, 6, 7, 0, 1));
        vecs.push_back(mk(7, 0, 0, 0,  2, 1, 6, 7, 0, 1));
        vecs.push_back(mk(5, 1, 0, 0,  3, 1, 6, 5, 1, 0));
        vecs.push_back(mk(5, 0, 0, 0,  0, 1, 6, 5, 0, 0));
        // Enter and cancel rising together in S_B: cancel wins, sw not latched
        vecs.push_back(mk(2, 1, 0, 0,  1, 2, 6, 5, 0, 0));
        vecs.push_back(mk(2, 0, 0, 0,  1, 2, 6, 5, 0, 0));
        vecs.push_back(mk(7, 1, 1, 0,  0, 2, 6, 5, 0, 0));
        vecs.push_back(mk(7, 0, 0, 0,  0, 2, 6, 5, 0, 0));
        // Cancel after a refused push clears err and keeps the latches
        vecs.push_back(mk(0, 1, 0, 0,  1, 0, 6, 5, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  1, 0, 6, 5, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0,  2, 0, 1, 5, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,  2, 0, 1, 5, 0, 0));
        vecs.push_back(mk(3, 1, 0, 1,  2, 0, 1, 3, 0, 1));
        vecs.push_back(mk(3, 0, 0, 1,  2, 0, 1, 3, 0, 1));
        vecs.push_back(mk(6, 0, 1, 1,  0, 0, 1, 3, 0, 0));
        vecs.push_back(mk(6, 0, 0, 0,  0, 0, 1, 3, 0, 0));
        // Held enter advances only once
        vecs.push_back(mk(4, 1, 0, 0,  1, 4, 1, 3, 0, 0));
        vecs.push_back(mk(5, 1, 0, 0,  1, 4, 1, 3, 0, 0));
        vecs.push_back(mk(5, 1, 0, 0,  1, 4, 1, 3, 0, 0));
        vecs.push_back(mk(5, 0, 0, 0,  1, 4, 1, 3, 0, 0));

        // Reset state
        #1;
        check_all("reset", 0, 0, 0, 0, 0, 0);
        do_reset();
        check_all("post_reset", 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            sw        = vecs[i].sw;
            enter     = vecs[i].en;
            cancel    = vecs[i].ca;
            lifo_full = vecs[i].lf;
            step();
            check_all($sformatf("row%0d", i), int'(vecs[i].st), int'(vecs[i].a),
                      int'(vecs[i].b), int'(vecs[i].op), int'(vecs[i].calc),
                      int'(vecs[i].err));
        end

        // Reset release with enter held: no edge and no latch
        sw     = 3'd6;
        enter  = 1'b1;
        cancel = 1'b0;
        lifo_full = 1'b0;
        reset_n = 1'b0;
        #1;
        check_all("async_reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk_300hz);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) step();
        check_all("held_enter", 0, 0, 0, 0, 0, 0);
        enter = 1'b0;
        step();
        enter = 1'b1;
        step();
        check_all("held_enter_release", 1, 6, 0, 0, 0, 0);
        enter = 1'b0;

        // Idle in S_B (entered on the previous edge)
`ifdef OPSEQ_TIMEOUT_EN
        for (int k = 0; k < 3; k++) step();
        check("timeout_before stage", int'(stage), 1);
        check("timeout_before err", int'(err), 0);
        step();
        check("timeout stage", int'(stage), 0);
        check("timeout err", int'(err), 1);
        check("timeout a_out", int'(a_out), 6);
`else
        for (int k = 0; k < 100; k++) step();
        check("no_timeout stage", int'(stage), 1);
        check("no_timeout err", int'(err), 0);
`endif

        // Reset during S_ISSUE truncates the push
        do_reset();
        sw = 3'd1; enter = 1'b1; step(); enter = 1'b0; step();
        sw = 3'd2; enter = 1'b1; step(); enter = 1'b0; step();
        sw = 3'd3; enter = 1'b1; step();
        check_all("issue", 3, 1, 2, 3, 1, 0);
        enter = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        check_all("issue_reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk_300hz);
        reset_n = 1'b1;
        step();
        check("issue_reset calc_after1", int'(calc_pulse), 0);
        step();
        check("issue_reset calc_after2", int'(calc_pulse), 0);
        check("issue_reset stage_after", int'(stage), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
